// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV64I core: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Drives the fetch/data memory handshakes, datapath selects and strobes, and counts retired instructions.
module cpu_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        dec_we,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic [63:0] instret,
    output logic [2:0]  state
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [63:0]      instret_q, instret_d;

    logic is_load, is_store, is_legal, br_taken;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_legal = (opcode == OP_R)    || (opcode == OP_I)     || is_load || is_store ||
                      (opcode == OP_BR)   || (opcode == OP_JALR)  || (opcode == OP_LUI)  ||
                      (opcode == OP_AUIPC)|| (opcode == OP_JAL)   || (opcode == OP_FENCE);

    // Branch condition from funct3 and ALU flags; 010/011 are never taken
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:         br_taken = alu_zero;
            3'b001:         br_taken = ~alu_zero;
            3'b100, 3'b110: br_taken = alu_lt;
            3'b101, 3'b111: br_taken = ~alu_lt;
            default:        br_taken = 1'b0;
        endcase
    end

    // State, memory-wait counter and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and control outputs; requests are gated by rst_n so they drop the instant reset asserts
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        alu_a_sel = 2'b00;
        alu_b_sel = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        trap      = 1'b0;

        // Operand selects are held from EXEC through WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (opcode)
                OP_I, OP_LOAD, OP_STORE, OP_JALR: alu_b_sel = 1'b1;
                OP_LUI: begin
                    alu_a_sel = 2'b10;
                    alu_b_sel = 1'b1;
                end
                OP_AUIPC, OP_JAL: begin
                    alu_a_sel = 2'b01;
                    alu_b_sel = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                imem_req = rst_n;
                if (imem_ack) begin
                    ir_we   = rst_n;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                wait_d  = '0;
                state_d = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                wait_d  = '0;
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = rst_n;
                dmem_we  = rst_n & is_store;
                if (dmem_ack) begin
                    wait_d  = '0;
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_we = dec_we;
                pc_we = 1'b1;
                if (is_load)
                    wb_sel = 2'b01;
                else if (opcode == OP_JAL || opcode == OP_JALR)
                    wb_sel = 2'b10;
                if (opcode == OP_JAL)
                    pc_sel = 2'b01;
                else if (opcode == OP_JALR)
                    pc_sel = 2'b10;
                else if (opcode == OP_BR && br_taken)
                    pc_sel = 2'b01;
                instret_d = instret_q + 64'd1;
                wait_d    = '0;
                state_d   = S_FETCH;
            end
            default: begin
                // TRAP and unused encodings: sticky until reset
                trap    = 1'b1;
                state_d = S_TRAP;
            end
        endcase
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: instruction sequences, branch outcomes, traps and reset abort.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack, ir_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        dec_we, alu_zero, alu_lt;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [63:0] instret;
    logic [2:0]  state;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_instret = 64'd0;

    cpu_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .opcode(opcode), .funct3(funct3), .dec_we(dec_we),
        .alu_zero(alu_zero), .alu_lt(alu_lt),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .trap(trap), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full instruction starting right after a negedge in FETCH; ack on the first fetch cycle
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic we, input logic zero, input logic lt,
                             input logic is_mem, input logic is_st, input int waits,
                             input logic [1:0] ea, input logic eb,
                             input logic [1:0] ewb, input logic [1:0] epc);
        opcode = op; funct3 = f3; dec_we = we; alu_zero = zero; alu_lt = lt;
        imem_ack = 1'b1;
        #1;
        check({tag, "/fetch_req"}, 64'(imem_req), 64'd1);
        check({tag, "/ir_we"}, 64'(ir_we), 64'd1);
        @(negedge clk); imem_ack = 1'b0; #1;
        check({tag, "/decode"}, 64'(state), 64'd1);
        check({tag, "/ir_we_pulse"}, 64'(ir_we), 64'd0);
        @(negedge clk); #1;
        check({tag, "/exec"}, 64'(state), 64'd2);
        check({tag, "/exec_a"}, 64'(alu_a_sel), 64'(ea));
        check({tag, "/exec_b"}, 64'(alu_b_sel), 64'(eb));
        if (is_mem) begin
            for (int i = 0; i < waits; i++) begin
                @(negedge clk); #1;
                check({tag, "/mem_wait"}, 64'(state), 64'd3);
                check({tag, "/dmem_req"}, 64'(dmem_req), 64'd1);
                check({tag, "/dmem_we"}, 64'(dmem_we), 64'(is_st));
            end
            @(negedge clk); dmem_ack = 1'b1; #1;
            check({tag, "/ack_cycle_req"}, 64'(dmem_req), 64'd1);
            check({tag, "/ack_cycle_we"}, 64'(dmem_we), 64'(is_st));
            @(negedge clk); dmem_ack = 1'b0;
        end else begin
            @(negedge clk);
        end
        #1;
        check({tag, "/wb"}, 64'(state), 64'd4);
        check({tag, "/rf_we"}, 64'(rf_we), 64'(we));
        check({tag, "/wb_sel"}, 64'(wb_sel), 64'(ewb));
        check({tag, "/pc_we"}, 64'(pc_we), 64'd1);
        check({tag, "/pc_sel"}, 64'(pc_sel), 64'(epc));
        check({tag, "/wb_a_held"}, 64'(alu_a_sel), 64'(ea));
        exp_instret = exp_instret + 64'd1;
        @(negedge clk); #1;
        check({tag, "/back_fetch"}, 64'(state), 64'd0);
        check({tag, "/instret"}, instret, exp_instret);
        check({tag, "/pc_we_pulse"}, 64'(pc_we), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 64'd0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; dec_we = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
        #1;
        // Reset values
        check("rst/state", 64'(state), 64'd0);
        check("rst/instret", instret, 64'd0);
        check("rst/trap", 64'(trap), 64'd0);
        check("rst/imem_req", 64'(imem_req), 64'd0);
        check("rst/dmem_req", 64'(dmem_req), 64'd0);
        check("rst/pc_we", 64'(pc_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD, LW (3 waits), SW, branches, jumps, U-type
        run_instr("add",   7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b00);
        run_instr("lw",    7'b0000011, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 2'b00, 1'b1, 2'b01, 2'b00);
        run_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2'b00, 1'b1, 2'b00, 2'b00);
        run_instr("bne",   7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b01);
        run_instr("beq",   7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b00);
        run_instr("blt",   7'b1100011, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b01);
        run_instr("bge",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b00);
        run_instr("b010",  7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b00);
        run_instr("jal",   7'b1101111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b01, 1'b1, 2'b10, 2'b01);
        run_instr("jalr",  7'b1100111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b1, 2'b10, 2'b10);
        run_instr("lui",   7'b0110111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b10, 1'b1, 2'b00, 2'b00);
        run_instr("auipc", 7'b0010111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b01, 1'b1, 2'b00, 2'b00);
        run_instr("fence", 7'b0001111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b00);

        // Stray acks while in DECODE/EXEC must not change the flow
        opcode = 7'b0010011; funct3 = 3'b000; dec_we = 1'b1; imem_ack = 1'b1; #1;
        @(negedge clk); imem_ack = 1'b1; dmem_ack = 1'b1; #1;
        check("stray/decode", 64'(state), 64'd1);
        @(negedge clk); #1;
        check("stray/exec", 64'(state), 64'd2);
        check("stray/no_dmem_req", 64'(dmem_req), 64'd0);
        @(negedge clk); imem_ack = 1'b0; dmem_ack = 1'b0; #1;
        check("stray/wb", 64'(state), 64'd4);
        exp_instret = exp_instret + 64'd1;
        @(negedge clk); #1;
        check("stray/instret", instret, exp_instret);

        // Data-memory timeout: 16 cycles of dmem_req without ack, then TRAP
        opcode = 7'b0000011; funct3 = 3'b010; dec_we = 1'b1; imem_ack = 1'b1; #1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            check("tmo/mem_req", 64'(dmem_req), 64'd1);
        end
        @(negedge clk); #1;
        check("tmo/state", 64'(state), 64'd5);
        check("tmo/trap", 64'(trap), 64'd1);
        check("tmo/dmem_req", 64'(dmem_req), 64'd0);
        check("tmo/instret", instret, exp_instret);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        @(negedge clk); #1;
        check("tmo/sticky", 64'(state), 64'd5);
        check("tmo/imem_req", 64'(imem_req), 64'd0);
        check("tmo/ir_we", 64'(ir_we), 64'd0);
        check("tmo/pc_we", 64'(pc_we), 64'd0);
        check("tmo/frozen", instret, exp_instret);

        // Illegal opcodes 0x7F and SYSTEM both trap after DECODE
        do_reset();
        #1;
        check("ill/trap_cleared", 64'(trap), 64'd0);
        check("ill/instret_cleared", instret, 64'd0);
        opcode = 7'h7F; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0; #1;
        check("ill7f/decode", 64'(state), 64'd1);
        @(negedge clk); #1;
        check("ill7f/state", 64'(state), 64'd5);
        check("ill7f/trap", 64'(trap), 64'd1);
        @(negedge clk); #1;
        check("ill7f/no_imem_req", 64'(imem_req), 64'd0);
        do_reset();
        opcode = 7'b1110011; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk); #1;
        check("sys/state", 64'(state), 64'd5);
        check("sys/trap", 64'(trap), 64'd1);
        check("sys/instret", instret, 64'd0);

        // Reset in the middle of a data access
        do_reset();
        run_instr("add2", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 2'b00);
        opcode = 7'b0100011; dec_we = 1'b0; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rstmid/dmem_req", 64'(dmem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid/req_drop", 64'(dmem_req), 64'd0);
        check("rstmid/we_drop", 64'(dmem_we), 64'd0);
        check("rstmid/state", 64'(state), 64'd0);
        check("rstmid/instret", instret, 64'd0);
        check("rstmid/imem_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid/refetch", 64'(imem_req), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
